// File: rtl/inst_fetch_responder_if.sv
// Exception_Pkg: fetch exception type shared by the responder and its users.
// inst_fetch_responder_if: fetch request/response handshake plus the instruction
// memory read port of inst_fetch_responder.
//   fetch_req/fetch_addr/fetch_ready : request handshake (core -> responder)
//   flush                            : abort outstanding fetch, invalidate buffer
//   resp_valid/resp_addr/
//   resp_instruction/exception_resp  : one-cycle response pulse (no backpressure)
//   mem_rd_en/mem_addr/mem_rd_data   : synchronous fixed-latency memory read port
// Modports: slave = responder view; master = core-plus-memory environment view.

package Exception_Pkg;

  localparam logic [3:0] ExcCodeMisaligned  = 4'd0;
  localparam logic [3:0] ExcCodeAccessFault = 4'd1;

  typedef struct packed {
    logic       raise;
    logic [3:0] code;
  } exception_t;

endpackage

interface inst_fetch_responder_if #(
  parameter int unsigned DEPTH_WORDS = 2048
) ();

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic                      fetch_req;
  logic [31:0]               fetch_addr;
  logic                      fetch_ready;
  logic                      flush;
  logic                      resp_valid;
  logic [31:0]               resp_addr;
  logic [31:0]               resp_instruction;
  Exception_Pkg::exception_t exception_resp;
  logic                      mem_rd_en;
  logic [AW-1:0]             mem_addr;
  logic [31:0]               mem_rd_data;

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    input  flush,
    input  mem_rd_data,
    output fetch_ready,
    output resp_valid,
    output resp_addr,
    output resp_instruction,
    output exception_resp,
    output mem_rd_en,
    output mem_addr
  );

  // The environment side also owns the memory, so it drives mem_rd_data.
  modport master (
    output fetch_req,
    output fetch_addr,
    output flush,
    output mem_rd_data,
    input  fetch_ready,
    input  resp_valid,
    input  resp_addr,
    input  resp_instruction,
    input  exception_resp,
    input  mem_rd_en,
    input  mem_addr
  );

endinterface

// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: instruction-side responder for the fetch stage.
// Checks alignment and range of each fetch address, answers from a single-word
// line buffer on a hit, otherwise reads a fixed-latency synchronous instruction
// memory. Faulting fetches return instruction 0 with an exception.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   io_bus : inst_fetch_responder_if.slave (fetch handshake, response, memory port)
// Parameters:
//   ADDR_BASE   : byte address of instruction word 0
//   DEPTH_WORDS : memory depth in 32-bit words (power of two, >= 2)
//   MEM_LATENCY : cycles from mem_rd_en to valid mem_rd_data (1..4)

module inst_fetch_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  inst_fetch_responder_if.slave io_bus
);

  import Exception_Pkg::*;

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  // Byte span of the memory; 33 bits so the top-of-space case cannot overflow.
  localparam logic [32:0] Span    = 33'(DEPTH_WORDS) << 2;
  localparam logic [2:0]  LatLast = 3'(MEM_LATENCY);

  typedef enum logic [1:0] {StIdle, StRead, StResp} state_e;

  state_e        r_state,      w_state_d;
  logic [31:0]   r_req_addr,   w_req_addr_d;
  logic [2:0]    r_lat_cnt,    w_lat_cnt_d;
  logic          r_mem_rd_en,  w_mem_rd_en_d;
  logic [AW-1:0] r_mem_addr,   w_mem_addr_d;
  logic          r_buf_valid,  w_buf_valid_d;
  logic [31:0]   r_buf_tag,    w_buf_tag_d;
  logic [31:0]   r_buf_data,   w_buf_data_d;
  logic          r_resp_valid, w_resp_valid_d;
  logic [31:0]   r_resp_addr,  w_resp_addr_d;
  logic [31:0]   r_resp_instr, w_resp_instr_d;
  exception_t    r_exc,        w_exc_d;

  logic          w_fetch_ready;
  logic          w_accept;
  logic [32:0]   w_offset;
  logic          w_misaligned;
  logic          w_fault;
  logic          w_hit;
  logic [AW-1:0] w_word_idx;

  assign w_fetch_ready = ((r_state == StIdle) || (r_state == StResp)) && !io_bus.flush;
  assign w_accept      = io_bus.fetch_req && w_fetch_ready;

  // Offset borrow (bit 32) means the address lies below ADDR_BASE.
  assign w_offset     = {1'b0, io_bus.fetch_addr} - {1'b0, ADDR_BASE};
  assign w_misaligned = |io_bus.fetch_addr[1:0];
  assign w_fault      = w_offset[32] || (w_offset >= Span);
  assign w_hit        = r_buf_valid && (r_buf_tag == io_bus.fetch_addr);
  assign w_word_idx   = AW'(w_offset >> 2);

  always_comb begin
    w_state_d      = r_state;
    w_req_addr_d   = r_req_addr;
    w_lat_cnt_d    = r_lat_cnt;
    w_mem_rd_en_d  = 1'b0;
    w_mem_addr_d   = r_mem_addr;
    w_buf_valid_d  = r_buf_valid;
    w_buf_tag_d    = r_buf_tag;
    w_buf_data_d   = r_buf_data;
    w_resp_valid_d = 1'b0;
    w_resp_addr_d  = r_resp_addr;
    w_resp_instr_d = r_resp_instr;
    w_exc_d        = r_exc;

    unique case (r_state)
      StIdle, StResp: begin
        if (w_accept) begin
          if (w_misaligned || w_fault) begin
            w_state_d      = StResp;
            w_resp_valid_d = 1'b1;
            w_resp_addr_d  = io_bus.fetch_addr;
            w_resp_instr_d = '0;
            w_exc_d.raise  = 1'b1;
            w_exc_d.code   = w_misaligned ? ExcCodeMisaligned : ExcCodeAccessFault;
          end else if (w_hit) begin
            w_state_d      = StResp;
            w_resp_valid_d = 1'b1;
            w_resp_addr_d  = io_bus.fetch_addr;
            w_resp_instr_d = r_buf_data;
            w_exc_d        = '0;
          end else begin
            w_state_d     = StRead;
            w_req_addr_d  = io_bus.fetch_addr;
            w_mem_addr_d  = w_word_idx;
            w_mem_rd_en_d = 1'b1;
            w_lat_cnt_d   = '0;
          end
        end else begin
          w_state_d = StIdle;
        end
      end
      StRead: begin
        // Count 0 is the strobe cycle; data is valid once MEM_LATENCY cycles have passed.
        if (r_lat_cnt == LatLast) begin
          w_state_d      = StResp;
          w_lat_cnt_d    = '0;
          w_buf_valid_d  = 1'b1;
          w_buf_tag_d    = r_req_addr;
          w_buf_data_d   = io_bus.mem_rd_data;
          w_resp_valid_d = 1'b1;
          w_resp_addr_d  = r_req_addr;
          w_resp_instr_d = io_bus.mem_rd_data;
          w_exc_d        = '0;
        end else begin
          w_lat_cnt_d = r_lat_cnt + 3'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Flush wins over everything: drop any read in flight and keep the
    // registered response fields at their last visible values.
    if (io_bus.flush) begin
      w_state_d      = StIdle;
      w_lat_cnt_d    = '0;
      w_mem_rd_en_d  = 1'b0;
      w_buf_valid_d  = 1'b0;
      w_buf_tag_d    = r_buf_tag;
      w_buf_data_d   = r_buf_data;
      w_resp_valid_d = 1'b0;
      w_resp_addr_d  = r_resp_addr;
      w_resp_instr_d = r_resp_instr;
      w_exc_d        = r_exc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_req_addr   <= '0;
      r_lat_cnt    <= '0;
      r_mem_rd_en  <= 1'b0;
      r_mem_addr   <= '0;
      r_buf_valid  <= 1'b0;
      r_buf_tag    <= '0;
      r_buf_data   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_addr  <= '0;
      r_resp_instr <= '0;
      r_exc        <= '0;
    end else begin
      r_state      <= w_state_d;
      r_req_addr   <= w_req_addr_d;
      r_lat_cnt    <= w_lat_cnt_d;
      r_mem_rd_en  <= w_mem_rd_en_d;
      r_mem_addr   <= w_mem_addr_d;
      r_buf_valid  <= w_buf_valid_d;
      r_buf_tag    <= w_buf_tag_d;
      r_buf_data   <= w_buf_data_d;
      r_resp_valid <= w_resp_valid_d;
      r_resp_addr  <= w_resp_addr_d;
      r_resp_instr <= w_resp_instr_d;
      r_exc        <= w_exc_d;
    end
  end

  assign io_bus.fetch_ready      = w_fetch_ready;
  assign io_bus.resp_valid       = r_resp_valid;
  assign io_bus.resp_addr        = r_resp_addr;
  assign io_bus.resp_instruction = r_resp_instr;
  assign io_bus.exception_resp   = r_exc;
  assign io_bus.mem_rd_en        = r_mem_rd_en;
  assign io_bus.mem_addr         = r_mem_addr;

endmodule
